alu_rr_arbiter: RTL and testbench
=================================

ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

Interface
REQ-001 Parameter LAT, default 1, meaning: ALU result latency in cycles after the operand select is applied (legal 1..15).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester ALU request, level, held until own rsp_valid.
REQ-005 flush  input  1  synchronous abort of in-flight operation.
REQ-006 alu_result  input  32  shared ALU output.
REQ-007 sel  output  2  operand-mux select: requester0=2'b00, requester1=2'b10, requester2=2'b01, requester3=2'b11.
REQ-008 gnt  output  4  one-hot owner of the ALU, zero when idle.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 rsp_valid  output  4  one-hot single-cycle response strobe to the owner.
REQ-011 rsp_data  output  32  registered ALU result, valid while any rsp_valid bit high.

Function
REQ-012 FSM states SHALL be IDLE, GRANT, WAIT, DONE; all outputs registered.
REQ-013 IDLE: if req!=0, select winner, go GRANT next cycle; else stay IDLE.
REQ-014 Winner SHALL be the first set req bit scanning upward (mod 4) from ptr, where ptr = last completed owner + 1.
REQ-015 GRANT: gnt=one-hot(winner), sel=encoding(winner), go WAIT; wait counter loaded with LAT.
REQ-016 WAIT: gnt and sel held constant; counter decrements each cycle; on the cycle counter==1, rsp_data <= alu_result and go DONE.
REQ-017 DONE: rsp_valid=one-hot(owner) for exactly one cycle; gnt still asserted; ptr <= owner+1 (wrap 3->0); go IDLE.
REQ-018 Latency: req seen in IDLE at cycle T -> GRANT at T+1 -> rsp_valid at T+2+LAT; one op per LAT+3 cycles.
REQ-019 sel SHALL hold its last value in IDLE (no glitch to 00 between ops); gnt=0 in IDLE.
REQ-020 Requester dropping req after GRANT: operation completes, response still delivered.
REQ-021 req changes after GRANT SHALL not alter owner, sel or gnt until DONE.
REQ-022 flush in GRANT or WAIT: go IDLE next cycle, no rsp_valid, rsp_data unchanged, ptr unchanged.
REQ-023 flush in DONE: ignored, response delivered; flush in IDLE: no effect, request arbitration proceeds.
REQ-024 Only one bit of gnt and of rsp_valid SHALL ever be set; rsp_valid bit SHALL equal gnt bit in the same cycle.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, sel=2'b00, gnt=0, busy=0, rsp_valid=0, rsp_data=0, ptr=0, counter=0.
REQ-026 Reset mid-operation SHALL drop the operation with no response; first arbitration after release starts at requester0.

Verification
REQ-027 LAT=1, reset release, req=4'b0100, alu_result=32'hDEAD_BEEF -> gnt=4'b0100, sel=2'b01 at T+1; rsp_valid=4'b0100, rsp_data=32'hDEAD_BEEF at T+3; busy low at T+4.
REQ-028 LAT=1, req=4'b1111 held continuously -> grant order 0,1,2,3,0 with sel 00,10,01,11,00, one grant every 4 cycles.
REQ-029 LAT=3, req=4'b0010, flush pulsed second WAIT cycle -> IDLE next cycle, no rsp_valid, then req still high regranted to requester1.
REQ-030 LAT=2, owner requester3, req[3] deasserted during WAIT -> rsp_valid=4'b1000 still pulses; next grant starts scan at requester0.
REQ-031 rst_n asserted during WAIT with gnt=4'b0010 -> gnt=0, sel=00, busy=0 asynchronously; no rsp_valid after release.
REQ-032 Random req/flush for 10k cycles -> checker: gnt/rsp_valid one-hot, sel matches gnt encoding, no requester starved beyond 3 other grants.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that lends a shared fixed-latency ALU to four requesters
// and returns the registered result to the owner as a single-cycle strobe.
module alu_rr_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic        flush,
    input  logic [31:0] alu_result,
    output logic [1:0]  sel,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic [3:0]  rsp_valid,
    output logic [31:0] rsp_data
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IW   = 2;
    localparam int unsigned CW   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   win_idx;
    logic [CW-1:0]   cnt;

    // First requester at or after ptr; descending loop lets the nearest one win.
    always_comb begin
        win_idx = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[ptr + IW'(i)]) begin
                win_idx = ptr + IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        state <= GRANT;
                        owner <= win_idx;
                        gnt   <= NREQ'(1) << win_idx;
                        // Operand mux wants the requester index bit-reversed.
                        sel   <= {win_idx[0], win_idx[1]};
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (flush) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= CW'(LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            rsp_data  <= alu_result;
                            rsp_valid <= gnt;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= owner + IW'(1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: three instances (LAT 1,2,3), directed scenarios,
// then random req/flush against a transaction-level model and scoreboard.
module tb_alu_rr_arbiter;

    localparam int unsigned NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req     [NI];
    logic        flush   [NI];
    logic [31:0] alu_res [NI];
    logic [1:0]  sel_w   [NI];
    logic [3:0]  gnt_w   [NI];
    logic        busy_w  [NI];
    logic [3:0]  rv_w    [NI];
    logic [31:0] rd_w    [NI];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] enc(input int r);
        case (r)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    function automatic int first_from(input int p, input logic [3:0] rq);
        for (int off = 0; off < 4; off++) begin
            if (rq[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int L = k + 1;

        alu_rr_arbiter #(.LAT(L)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req        (req[k]),
            .flush      (flush[k]),
            .alu_result (alu_res[k]),
            .sel        (sel_w[k]),
            .gnt        (gnt_w[k]),
            .busy       (busy_w[k]),
            .rsp_valid  (rv_w[k]),
            .rsp_data   (rd_w[k])
        );

        exp_t        q[$];
        exp_t        e;
        bit          active;
        int          owner, ptr, start, pcnt, age;
        logic [1:0]  sel_e;
        logic [31:0] data_e;
        logic [3:0]  req_arb;
        int          starve [4];

        // Model: an op occupies posedges start..start+LAT+2 of a free-running count.
        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                active = 1'b0; ptr = 0; owner = 0; sel_e = 2'b00; data_e = '0;
                pcnt = 0; q.delete();
                for (int r = 0; r < 4; r++) starve[r] = 0;
            end else begin
                pcnt++;
                if (active) begin
                    age = pcnt - start;
                    if (age <= L + 1 && flush[k]) begin
                        active = 1'b0;
                    end else if (age == L + 1) begin
                        data_e = alu_res[k];
                        q.push_back('{owner, alu_res[k], pcnt});
                    end else if (age == L + 2) begin
                        active = 1'b0;
                        ptr = (owner + 1) % 4;
                        for (int r = 0; r < 4; r++) begin
                            if (r == owner || !req_arb[r]) starve[r] = 0;
                            else begin
                                starve[r]++;
                                chk($sformatf("starve%0d_r%0d", k, r), 32'(starve[r] <= 3), 32'd1);
                            end
                        end
                    end
                end else if (req[k] != 4'b0) begin
                    owner   = first_from(ptr, req[k]);
                    active  = 1'b1;
                    start   = pcnt;
                    sel_e   = enc(owner);
                    req_arb = req[k];
                end
            end
        end

        // Monitor: compare DUT outputs with the model away from the active edge.
        initial forever begin
            @(negedge clk);
            if (rst_n) begin
                chk($sformatf("gnt%0d", k), 32'(gnt_w[k]), active ? 32'(4'(1) << owner) : 32'd0);
                chk($sformatf("sel%0d", k), 32'(sel_w[k]), 32'(sel_e));
                chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(active));
                chk($sformatf("rsp_data_hold%0d", k), rd_w[k], data_e);
                if (rv_w[k] != 4'b0) begin
                    if (q.size() == 0) begin
                        chk($sformatf("rsp_unexpected%0d", k), 32'(rv_w[k]), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("rsp_valid%0d", k), 32'(rv_w[k]), 32'(4'(1) << e.owner));
                        chk($sformatf("rsp_time%0d", k), 32'(pcnt), 32'(e.due));
                        chk($sformatf("rsp_data%0d", k), rd_w[k], e.data);
                        chk($sformatf("rsp_eq_gnt%0d", k), 32'(rv_w[k]), 32'(gnt_w[k]));
                    end
                end else if (q.size() > 0 && q[0].due <= pcnt) begin
                    e = q.pop_front();
                    chk($sformatf("rsp_missing%0d", k), 32'(rv_w[k]), 32'(4'(1) << e.owner));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req[k] = '0; flush[k] = 1'b0; alu_res[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_sel", 32'(sel_w[0]), 32'd0);
        chk("reset_gnt", 32'(gnt_w[0]), 32'd0);
        chk("reset_busy", 32'(busy_w[0]), 32'd0);
        chk("reset_rsp_valid", 32'(rv_w[0]), 32'd0);
        chk("reset_rsp_data", rd_w[0], 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single op on LAT=1 requester2
        req[0] = 4'b0100; alu_res[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("d027_gnt", 32'(gnt_w[0]), 32'h4);
        chk("d027_sel", 32'(sel_w[0]), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("d027_rsp_valid", 32'(rv_w[0]), 32'h4);
        chk("d027_rsp_data", rd_w[0], 32'hDEAD_BEEF);
        req[0] = 4'b0;
        @(negedge clk);
        chk("d027_busy_low", 32'(busy_w[0]), 32'd0);
        chk("d027_sel_hold", 32'(sel_w[0]), 32'h1);

        // Reset during WAIT on LAT=2
        req[1] = 4'b0010;
        @(negedge clk);
        chk("d031_gnt_before", 32'(gnt_w[1]), 32'h2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("d031_gnt", 32'(gnt_w[1]), 32'd0);
        chk("d031_sel", 32'(sel_w[1]), 32'd0);
        chk("d031_busy", 32'(busy_w[1]), 32'd0);
        req[1] = 4'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("d031_no_rsp", 32'(rv_w[1]), 32'd0);
        end

        // Continuous requests on LAT=1: 0,1,2,3,0 every 4 cycles
        req[0] = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk($sformatf("d028_gnt%0d", g), 32'(gnt_w[0]), 32'(4'(1) << (g % 4)));
            chk($sformatf("d028_sel%0d", g), 32'(sel_w[0]), 32'(enc(g % 4)));
            if (g == 4) req[0] = 4'b0;
            else repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        // Flush in second WAIT cycle on LAT=3, then regrant
        req[2] = 4'b0010;
        repeat (3) @(negedge clk);
        flush[2] = 1'b1;
        @(negedge clk);
        flush[2] = 1'b0;
        chk("d029_idle_gnt", 32'(gnt_w[2]), 32'd0);
        chk("d029_idle_busy", 32'(busy_w[2]), 32'd0);
        chk("d029_no_rsp", 32'(rv_w[2]), 32'd0);
        @(negedge clk);
        chk("d029_regrant", 32'(gnt_w[2]), 32'h2);
        for (int i = 0; i < 12 && rv_w[2] == 4'b0; i++) @(negedge clk);
        chk("d029_rsp", 32'(rv_w[2]), 32'h2);
        req[2] = 4'b0;

        // Owner 3 drops req during WAIT on LAT=2
        req[1] = 4'b1000;
        @(negedge clk);
        chk("d030_gnt", 32'(gnt_w[1]), 32'h8);
        @(negedge clk);
        req[1] = 4'b0;
        repeat (2) @(negedge clk);
        chk("d030_rsp", 32'(rv_w[1]), 32'h8);
        @(negedge clk);
        req[1] = 4'b1111;
        @(negedge clk);
        chk("d030_wrap_gnt", 32'(gnt_w[1]), 32'h1);
        req[1] = 4'b0;
        repeat (6) @(negedge clk);

        // Random traffic on all instances
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NI; k++) begin
                if ($urandom_range(7) == 0) req[k] = 4'($urandom);
                flush[k]   = ($urandom_range(31) == 0);
                alu_res[k] = $urandom;
            end
            @(negedge clk);
        end
        for (int k = 0; k < NI; k++) begin
            req[k] = '0; flush[k] = 1'b0;
        end
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
